controller_setpoint_ramp: RTL

Sequencer that sits in front of a servo controller's setpoint input. It replaces a hard setpoint jump with a rate-limited ramp.
- Receives a target, step size and step interval over the shared config bus.
- Walks M_AXIS_setpoint from its current value to the target in fixed steps, one step every "interval" clocks.
- Supports hold, abort and immediate-jump.
- Reports progress, and pulses completion when the target is reached.

---
 rtl/controller_setpoint_ramp_pkg.sv | 33 +++
 rtl/controller_setpoint_ramp_config_write_strobe.sv | 29 ++
 rtl/controller_setpoint_ramp.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/controller_setpoint_ramp_pkg.sv
// Shared definitions for the setpoint ramp sequencer: state encoding,
// config register layout and control bit positions.
package controller_setpoint_ramp_pkg;

    localparam int unsigned CONFIG_ADDR_W = 32;
    localparam int unsigned CONFIG_DATA_W = 512;
    localparam int unsigned CONFIG_WORD_W = 32;

    localparam int unsigned DEFAULT_RAMP_REG_ADDRESS = 99997;

    // 32-bit word indices inside config_data
    localparam int unsigned WORD_TARGET   = 0;
    localparam int unsigned WORD_STEP     = 1;
    localparam int unsigned WORD_INTERVAL = 2;
    localparam int unsigned WORD_CONTROL  = 3;

    // Bit positions inside the control word
    localparam int unsigned CTRL_GO    = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_JUMP  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ramp_state_t;

    typedef struct packed {
        logic jump;
        logic abort;
        logic go;
    } ramp_ctrl_t;

endpackage

// File: rtl/controller_setpoint_ramp_config_write_strobe.sv
// Config-bus write detector: one-cycle strobe on the first cycle the bus
// address matches this slave, re-armed only after the address goes away.
module controller_setpoint_ramp_config_write_strobe #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned address    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [addr_width-1:0] addr,
    output logic                  write_c
);

    logic match_c;
    logic match_q;

    assign match_c = (addr == addr_width'(address));

    // Previous-cycle address match history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_c;
        end
    end

    assign write_c = match_c & ~match_q;

endmodule

// File: rtl/controller_setpoint_ramp.sv
// Rate-limited setpoint sequencer: walks the servo setpoint toward a
// configured target in fixed steps, one step every 'interval' clocks.
module controller_setpoint_ramp
    import controller_setpoint_ramp_pkg::*;
#(
    parameter int unsigned ramp_reg_address = DEFAULT_RAMP_REG_ADDRESS,
    parameter int unsigned width_setpoint   = 32,
    parameter int unsigned width_interval   = 32
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [CONFIG_ADDR_W-1:0]         config_addr,
    input  logic [CONFIG_DATA_W-1:0]         config_data,
    input  logic                             hold,
    output logic signed [width_setpoint-1:0] M_AXIS_setpoint_tdata,
    output logic                             M_AXIS_setpoint_tvalid,
    output logic                             ramp_active,
    output logic                             ramp_done,
    output logic [width_setpoint-1:0]        ramp_remaining
);

    localparam int unsigned SP_W  = width_setpoint;
    localparam int unsigned EXT_W = width_setpoint + 1;
    localparam int unsigned IV_W  = width_interval;

    // Absolute distance between two signed setpoints, one guard bit wide
    function automatic logic [EXT_W-1:0] distance(
        input logic signed [SP_W-1:0] a,
        input logic signed [SP_W-1:0] b
    );
        logic [EXT_W-1:0] d;
        d = {a[SP_W-1], a} - {b[SP_W-1], b};
        return d[EXT_W-1] ? EXT_W'(-d) : d;
    endfunction

    ramp_state_t              state_q,    state_d;
    logic signed [SP_W-1:0]   setpoint_q, setpoint_d;
    logic signed [SP_W-1:0]   target_q,   target_d;
    logic [SP_W-1:0]          step_q,     step_d;
    logic [IV_W-1:0]          interval_q, interval_d;
    logic [IV_W-1:0]          count_q,    count_d;
    logic [SP_W-1:0]          remaining_q, remaining_d;
    logic                     pending_q,  pending_d;
    logic                     done_q,     done_d;
    logic                     active_q,   active_d;
    logic                     valid_q;

    logic                     write_c;
    logic [CONFIG_WORD_W-1:0] word_target;
    logic [CONFIG_WORD_W-1:0] word_step;
    logic [CONFIG_WORD_W-1:0] word_interval;
    logic [CONFIG_WORD_W-1:0] word_control;
    ramp_ctrl_t               ctrl_c;
    logic                     unused_bits;

    logic [IV_W-1:0]          interval_last_c;
    logic [EXT_W-1:0]         mag_c;
    logic [EXT_W-1:0]         step_ext_c;
    logic [EXT_W-1:0]         setpoint_ext_c;
    logic [EXT_W-1:0]         toward_c;
    logic                     reach_c;

    controller_setpoint_ramp_config_write_strobe #(
        .addr_width (CONFIG_ADDR_W),
        .address    (ramp_reg_address)
    ) u_write_strobe (
        .clk     (aclk),
        .rst_n   (aresetn),
        .addr    (config_addr),
        .write_c (write_c)
    );

    assign word_target   = config_data[WORD_TARGET*CONFIG_WORD_W   +: CONFIG_WORD_W];
    assign word_step     = config_data[WORD_STEP*CONFIG_WORD_W     +: CONFIG_WORD_W];
    assign word_interval = config_data[WORD_INTERVAL*CONFIG_WORD_W +: CONFIG_WORD_W];
    assign word_control  = config_data[WORD_CONTROL*CONFIG_WORD_W  +: CONFIG_WORD_W];

    assign ctrl_c = ramp_ctrl_t'({word_control[CTRL_JUMP],
                                  word_control[CTRL_ABORT],
                                  word_control[CTRL_GO]});

    // Reserved control bits and the upper config words are not used here
    assign unused_bits = ^{config_data[CONFIG_DATA_W-1:4*CONFIG_WORD_W],
                           word_control[CONFIG_WORD_W-1:3]};

    // An interval of 0 behaves as 1: step on every clock
    assign interval_last_c = (interval_q == '0) ? '0 : interval_q - IV_W'(1);

    // One step toward target, clamped so the ramp never overshoots
    assign mag_c          = distance(target_q, setpoint_q);
    assign step_ext_c     = {1'b0, step_q};
    assign setpoint_ext_c = {setpoint_q[SP_W-1], setpoint_q};
    assign reach_c        = (mag_c <= step_ext_c);
    assign toward_c       = (target_q < setpoint_q) ? setpoint_ext_c - step_ext_c
                                                    : setpoint_ext_c + step_ext_c;

    // Next-state, field latching and step sequencing
    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        target_d   = target_q;
        step_d     = step_q;
        interval_d = interval_q;
        count_d    = count_q;
        pending_d  = 1'b0;
        done_d     = pending_q;

        if (write_c) begin
            target_d   = SP_W'(word_target);
            step_d     = SP_W'(word_step);
            interval_d = IV_W'(word_interval);
        end

        if (write_c && ctrl_c.abort) begin
            state_d = ST_IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end else if (write_c && ctrl_c.jump) begin
            setpoint_d = target_d;
            state_d    = ST_IDLE;
            count_d    = '0;
            pending_d  = 1'b1;
            done_d     = 1'b0;
        end else if (write_c && ctrl_c.go) begin
            count_d = '0;
            done_d  = 1'b0;
            if ((target_d == setpoint_q) || (step_d == '0)) begin
                setpoint_d = target_d;
                state_d    = ST_IDLE;
                pending_d  = 1'b1;
            end else begin
                state_d = ST_RAMP;
            end
        end else if (state_q == ST_RAMP) begin
            if (pending_q) begin
                // Target reached last cycle: leave RAMP with the done pulse
                state_d = ST_IDLE;
                count_d = '0;
            end else if (!hold) begin
                if (count_q >= interval_last_c) begin
                    count_d = '0;
                    if (reach_c) begin
                        setpoint_d = target_q;
                        pending_d  = 1'b1;
                    end else begin
                        setpoint_d = SP_W'(toward_c);
                    end
                end else begin
                    count_d = count_q + IV_W'(1);
                end
            end
        end

        active_d    = (state_d == ST_RAMP);
        remaining_d = SP_W'(distance(target_d, setpoint_d));
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            setpoint_q  <= '0;
            target_q    <= '0;
            step_q      <= '0;
            interval_q  <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
            active_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            setpoint_q  <= setpoint_d;
            target_q    <= target_d;
            step_q      <= step_d;
            interval_q  <= interval_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
            active_q    <= active_d;
            valid_q     <= 1'b1;
        end
    end

    assign M_AXIS_setpoint_tdata  = setpoint_q;
    assign M_AXIS_setpoint_tvalid = valid_q;
    assign ramp_active            = active_q;
    assign ramp_done              = done_q;
    assign ramp_remaining         = remaining_q;

endmodule
